mem_port_arbiter: RTL

- Shares the single unified instruction/data memory of the multicycle core between two requesters: the CPU (port c_) and the program loader/debug port (port d_).
- Serialises accesses, drives the memory port, and returns read data with a one-cycle ack pulse. The CPU controller holds its current state until c_ack.
- Sits between the datapath memory-address mux (iord) and the memory macro.

---
 rtl/mem_port_arbiter.sv | 91 +++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises CPU and loader accesses onto one memory port
module mem_port_arbiter #(
  parameter int LAT        = 1,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        c_req_i,
  input  logic        c_we_i,
  input  logic [31:0] c_addr_i,
  input  logic [31:0] c_wdata_i,
  output logic        c_ack_o,
  output logic [31:0] c_rdata_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_ack_o,
  output logic [31:0] d_rdata_o,
  output logic        m_en_o,
  output logic        m_we_o,
  output logic [31:0] m_addr_o,
  output logic [31:0] m_wdata_o,
  input  logic [31:0] m_rdata_i,
  output logic        busy_o,
  output logic        owner_o
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;
  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);
  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        owner_q, owner_d;
  logic        m_en_q, m_we_q, c_ack_q, d_ack_q;
  logic [31:0] m_addr_q, m_wdata_q, c_rdata_q, d_rdata_q;
  // Grantee when leaving IDLE: lone requester, else CPU or the port that lost last time
  always_comb owner_d = (c_req_i && d_req_i) ? (FIXED_PRIO ? 1'b0 : ~owner_q) : d_req_i;
  // Sequencer: grant in IDLE, strobe once, count down latency, pulse the owner's ack
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      owner_q   <= 1'b1;
      m_en_q    <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      c_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      c_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      c_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      case (state_q)
        IDLE: if (c_req_i || d_req_i) begin
          owner_q   <= owner_d;
          m_we_q    <= owner_d ? d_we_i : c_we_i;
          m_addr_q  <= owner_d ? d_addr_i : c_addr_i;
          m_wdata_q <= owner_d ? d_wdata_i : c_wdata_i;
          cnt_q     <= CNT_INIT;
          m_en_q    <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          m_en_q  <= 1'b0;
          state_q <= WAIT;
        end
        WAIT: if (cnt_q == '0) begin
          if (owner_q) d_rdata_q <= m_rdata_i;
          else c_rdata_q <= m_rdata_i;
          c_ack_q <= ~owner_q;
          d_ack_q <= owner_q;
          state_q <= DONE;
        end else begin
          cnt_q <= cnt_q - 4'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy_o    = state_q != IDLE;
  assign owner_o   = owner_q;
  assign m_en_o    = m_en_q;
  assign m_we_o    = m_we_q;
  assign m_addr_o  = m_addr_q;
  assign m_wdata_o = m_wdata_q;
  assign c_ack_o   = c_ack_q;
  assign d_ack_o   = d_ack_q;
  assign c_rdata_o = c_rdata_q;
  assign d_rdata_o = d_rdata_q;
endmodule
